// File: rtl/fp16_vec_packer.sv
// ============================================================================
//  Module      : fp16_vec_packer
//  Description : Packs a valid/ready stream of FP16 words into an N-lane flat
//                vector, zero-padding vectors closed early by in_last.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_vec_packer #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [N*16-1:0] out_flat,
  output logic            out_valid,
  output logic [CW-1:0]   out_count,
  output logic            out_last,
  input  logic            out_ready
);

  localparam logic [0:0] c_FILL = 1'b0;
  localparam logic [0:0] c_FULL = 1'b1;

  logic [0:0]            r_state;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_out_count;
  logic                  r_out_last;
  logic [N-1:0][15:0]    r_lanes;

  logic                  w_accept;
  logic                  w_release;
  logic                  w_close;
  logic [CW-1:0]         w_new_count;

  assign in_ready    = (r_state == c_FILL) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_release   = (r_state == c_FULL) && out_ready;
  assign w_new_count = r_count + 1'b1;
  assign w_close     = w_accept && ((w_new_count == CW'(N)) || in_last);

  assign out_valid = (r_state == c_FULL);
  assign out_count = r_out_count;
  assign out_last  = r_out_last;
  assign out_flat  = r_lanes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_FILL;
      r_count     <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        c_FILL: begin
          if (w_accept) begin
            r_count <= w_new_count;
          end
          if (w_close) begin
            r_state     <= c_FULL;
            r_out_count <= w_new_count;
            r_out_last  <= in_last;
          end
        end
        c_FULL: begin
          if (w_release) begin
            r_state     <= c_FILL;
            r_count     <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
          end
        end
        default: r_state <= c_FILL;
      endcase
    end
  end

  // Lanes are cleared on release so a short next vector reads zero padding.
  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_lanes <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_accept && (r_count == CW'(i))) begin
          r_lanes[i] <= in_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp16_vec_packer.sv
// ============================================================================
//  Module      : tb_fp16_vec_packer
//  Description : Self-checking bench for fp16_vec_packer with a queue-based
//                reference model, directed cases and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp16_vec_packer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [N*16-1:0] out_flat;
  logic            out_valid;
  logic [CW-1:0]   out_count;
  logic            out_last;
  logic            out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model: elements of the vector being gathered, plus the vector on offer.
  logic [15:0]     m_q[$];
  bit              m_valid = 1'b0;
  logic [N*16-1:0] m_flat  = '0;
  int              m_count = 0;
  bit              m_last  = 1'b0;
  bit              rand_ready = 1'b0;
  bit              last_acc;

  fp16_vec_packer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_flat  (out_flat),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*16-1:0] obs, input logic [N*16-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model from the driven inputs, then compare.
  task automatic tick();
    bit rdy, acc, rel;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    rdy = !m_valid && !rst;
    acc = in_valid && rdy;
    rel = m_valid && out_ready;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0; m_flat = '0; m_count = 0; m_last = 1'b0;
    end else if (rel) begin
      m_valid = 1'b0; m_count = 0; m_last = 1'b0;
    end else if (acc) begin
      m_q.push_back(in_data);
      if (m_q.size() == N || in_last) begin
        m_valid = 1'b1;
        m_flat  = '0;
        foreach (m_q[i]) m_flat[i*16 +: 16] = m_q[i];
        m_count = m_q.size();
        m_last  = in_last;
        m_q.delete();
      end
    end
    chk("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
    chk("in_ready", {127'd0, in_ready}, {127'd0, !m_valid && !rst});
    chk("out_count", {{(N*16-CW){1'b0}}, out_count}, (N*16)'(m_count));
    chk("out_last", {127'd0, out_last}, {127'd0, m_last});
    if (m_valid) chk("out_flat", out_flat, m_flat);
  endtask

  // Present one element and hold it until the model says it was accepted.
  task automatic send(input logic [15:0] d, input bit last);
    int budget = 64;
    in_valid = 1'b1; in_data = d; in_last = last;
    last_acc = 1'b0;
    while (!last_acc && budget > 0) begin
      tick();
      budget--;
    end
    if (!last_acc) chk("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int budget = 64;
    out_ready = 1'b1; in_valid = 1'b0;
    while (m_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (m_valid) chk("drain_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    logic [15:0] t1 [8];
    logic [N*16-1:0] held;
    logic [15:0] v;
    t1 = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4580, 16'h46A0, 16'h47C0, 16'h48E0};

    // Reset
    rst = 1'b1;
    idle(2);
    chk("reset_flat", out_flat, '0);
    rst = 1'b0;
    idle(1);

    // Full vector back-to-back
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(t1[i], 1'b0);
    in_valid = 1'b0;
    chk("t1_flat", out_flat, 128'h48E0_47C0_46A0_4580_4400_4200_4000_3C00);
    chk("t1_count", (N*16)'(out_count), 128'd8);
    drain();

    // Partial vector closed by in_last
    out_ready = 1'b0;
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4200, 1'b1);
    in_valid = 1'b0;
    chk("t2_flat", out_flat, {80'd0, 16'h4200, 16'h4000, 16'h3C00});
    chk("t2_last", {127'd0, out_last}, 128'd1);
    drain();

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'($urandom), 1'b0);
    held = out_flat;
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_stable", out_flat, held);
    out_ready = 1'b1;
    tick();
    chk("t3_released", {127'd0, out_valid}, 128'd0);
    send(16'h1234, 1'b1);
    in_valid = 1'b0;
    chk("t3_lane0", out_flat, {112'd0, 16'h1234});
    drain();

    // Valid toggling with gaps
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 1'b0);
      idle(1);
    end
    chk("t4_count", (N*16)'(out_count), 128'd8);
    drain();

    // Reset in the middle of a fill
    for (int i = 0; i < 4; i++) send(16'hFFFF - 16'(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 1'b0);
    in_valid = 1'b0;
    chk("t5_flat", out_flat, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    drain();

    // in_last on lane N-1, then single-element vector
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h2000 + 16'(i), i == 7);
    in_valid = 1'b0;
    chk("t6_last8", {127'd0, out_last}, 128'd1);
    drain();
    out_ready = 1'b0;
    v = 16'($urandom);
    send(v, 1'b1);
    in_valid = 1'b0;
    chk("t6_single", out_flat, {112'd0, v});
    chk("t6_count1", (N*16)'(out_count), 128'd1);
    drain();

    // Randomized traffic: gaps, early ends, random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
